axis_frame_capture: RTL

- Single-clock AXI4-Stream capture buffer that sits directly downstream of the OSPFB FFT output.
- Waits for a frame boundary, then writes exactly FRAMES frames of FFT_LEN beats into an internal RAM and asserts `full`.
- Checks tlast placement on every frame; contents are read back through a synchronous read port (or dumped by the bench).

---
 rtl/axis_frame_capture.sv | 132 +++++++++++++
 1 files changed

// File: rtl/axis_frame_capture.sv
// Frame-aligned AXI4-Stream capture buffer for FFT output frames.
// Syncs on tlast, stores FRAMES*FFT_LEN beats with tuser, checks tlast placement, and offers a registered read port.
module axis_frame_capture #(
    parameter  int unsigned FFT_LEN = 128,
    parameter  int unsigned FRAMES  = 32,
    parameter  int unsigned DATA_W  = 32,
    parameter  int unsigned TUSER_W = 1,
    localparam int unsigned DEPTH   = FFT_LEN * FRAMES,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned FCW     = $clog2(FRAMES + 1),
    localparam int unsigned RW      = DATA_W + TUSER_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  s_axis_tdata,
    input  logic [TUSER_W-1:0] s_axis_tuser,
    input  logic               s_axis_tvalid,
    input  logic               s_axis_tlast,
    output logic               s_axis_tready,
    output logic               full,
    output logic               armed,
    output logic [FCW-1:0]     frame_cnt,
    output logic [15:0]        tlast_unexpected,
    output logic [15:0]        tlast_missing,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic [RW-1:0]      rd_data
);

    localparam int unsigned BW = $clog2(FFT_LEN);

    typedef enum logic [1:0] {
        S_SYNC    = 2'd0,
        S_CAPTURE = 2'd1,
        S_FULL    = 2'd2
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   wr_addr_q;
    logic [BW-1:0]   beat_idx_q;
    logic            full_q;
    logic            armed_q;
    logic [FCW-1:0]  frame_cnt_q;
    logic [15:0]     unexp_q;
    logic [15:0]     miss_q;
    logic [RW-1:0]   rd_data_q;
    logic [RW-1:0]   ram [DEPTH];

    logic accept;
    logic last_beat;
    logic last_addr;
    logic wr_en;

    // The block never back-pressures; tready only drops while reset is held.
    assign s_axis_tready = ~rst;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign last_beat     = (beat_idx_q == BW'(FFT_LEN - 1));
    assign last_addr     = (wr_addr_q == AW'(DEPTH - 1));
    assign wr_en         = accept && (state_q == S_CAPTURE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_SYNC;
            wr_addr_q   <= '0;
            beat_idx_q  <= '0;
            full_q      <= 1'b0;
            armed_q     <= 1'b0;
            frame_cnt_q <= '0;
            unexp_q     <= '0;
            miss_q      <= '0;
        end else begin
            case (state_q)
                S_SYNC: begin
                    // The tlast beat itself is dropped so capture starts frame-aligned.
                    if (accept && s_axis_tlast) begin
                        state_q <= S_CAPTURE;
                        armed_q <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (accept) begin
                        wr_addr_q  <= wr_addr_q + AW'(1);
                        beat_idx_q <= beat_idx_q + BW'(1);
                        if (last_beat) begin
                            frame_cnt_q <= frame_cnt_q + FCW'(1);
                        end
                        if (s_axis_tlast && !last_beat && (unexp_q != 16'hFFFF)) begin
                            unexp_q <= unexp_q + 16'd1;
                        end
                        if (!s_axis_tlast && last_beat && (miss_q != 16'hFFFF)) begin
                            miss_q <= miss_q + 16'd1;
                        end
                        if (last_addr) begin
                            state_q <= S_FULL;
                            armed_q <= 1'b0;
                            full_q  <= 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    state_q <= S_FULL;
                end
                default: begin
                    state_q <= S_SYNC;
                end
            endcase
        end
    end

    // Plain single-port-write / registered-read array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr_q] <= {s_axis_tuser, s_axis_tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= ram[rd_addr];
        end
    end

    assign full             = full_q;
    assign armed            = armed_q;
    assign frame_cnt        = frame_cnt_q;
    assign tlast_unexpected = unexp_q;
    assign tlast_missing    = miss_q;
    assign rd_data          = rd_data_q;

endmodule
